// File: rtl/credit_sw_arbiter_pkg.sv
// Shared constants, FSM state type and helpers for the credit-based switch arbiter.
package credit_sw_arbiter_pkg;

    localparam int NPORTS = 5;
    localparam int TW     = 3;

    localparam logic [TW-1:0] NONE  = 3'd0;
    localparam logic [TW-1:0] LOCAL = 3'd5;

    typedef enum logic {
        IDLE,
        LOCKED
    } out_state_e;

    // One-hot input vector to 1-based input number; NONE when empty.
    function automatic logic [TW-1:0] onehot_to_idx(input logic [NPORTS-1:0] v);
        logic [TW-1:0] r;
        r = NONE;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (v[i]) r = TW'(i + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/credit_sw_arbiter_rr_pick5.sv
// Combinational 5-way round-robin picker: searches from the input after ptr (1-based), wrapping.
module rr_pick5
    import credit_sw_arbiter_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  logic [TW-1:0]     ptr,
    output logic [NPORTS-1:0] gnt
);

    logic       found;
    logic [2:0] idx;

    // Bit position ptr is the input numbered ptr+1, so the search starts there.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < NPORTS; off++) begin
            idx = 3'((int'(ptr) + off) % NPORTS);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/credit_sw_arbiter.sv
// 5x5 wormhole switch allocator with per-output packet locks and credit flow control
// on outputs 1-4; allocation is combinational, state updates on the next edge.
module credit_sw_arbiter
    import credit_sw_arbiter_pkg::*;
#(
    parameter int BUF_DEPTH = 4,
    parameter int CW        = 3
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic [NPORTS*TW-1:0]       req_targ,
    input  logic [NPORTS-1:0]          req_tail,
    input  logic [NPORTS-2:0]          cred_in,
    output logic [NPORTS-1:0]          grant,
    output logic [NPORTS*TW-1:0]       out_sel,
    output logic [NPORTS-1:0]          out_valid,
    output logic [(NPORTS-1)*CW-1:0]   cred_cnt,
    output logic                       cred_err
);

    localparam int             NCRED = NPORTS - 1;
    localparam logic [CW-1:0]  FULL  = CW'(BUF_DEPTH);

    if (BUF_DEPTH < 1 || BUF_DEPTH > 7 || BUF_DEPTH >= (1 << CW)) begin : g_param_check
        $error("credit_sw_arbiter: BUF_DEPTH must be 1..7 and below 2**CW");
    end

    out_state_e        state     [NPORTS];
    out_state_e        state_nxt [NPORTS];
    logic [TW-1:0]     owner     [NPORTS];
    logic [TW-1:0]     owner_nxt [NPORTS];
    logic [TW-1:0]     rr_ptr    [NPORTS];
    logic [TW-1:0]     rr_ptr_nxt[NPORTS];
    logic [CW-1:0]     cnt       [NCRED];
    logic [CW-1:0]     cnt_nxt   [NCRED];
    logic              err_nxt;

    logic [NPORTS-1:0] credit_ok;
    logic [NPORTS-1:0] elig [NPORTS];
    logic [NPORTS-1:0] pick [NPORTS];
    logic [NPORTS-1:0] win  [NPORTS];

    // The local ejection port never runs out of buffer space.
    always_comb begin
        credit_ok = '1;
        for (int k = 0; k < NCRED; k++) begin
            credit_ok[k] = (cnt[k] != '0);
        end
    end

    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            for (int i = 0; i < NPORTS; i++) begin
                elig[p][i] = (req_targ[TW*i +: TW] == TW'(p + 1)) &&
                             (state[p] == IDLE || owner[p] == TW'(i + 1)) &&
                             credit_ok[p];
            end
        end
    end

    for (genvar p = 0; p < NPORTS; p++) begin : g_pick
        rr_pick5 u_pick (
            .req (elig[p]),
            .ptr (rr_ptr[p]),
            .gnt (pick[p])
        );
    end

    // A locked output can only ever have its owner eligible, so no picker is needed there.
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            win[p] = '0;
            if (RST) win[p] = (state[p] == IDLE) ? pick[p] : elig[p];
        end
    end

    always_comb begin
        grant     = '0;
        out_sel   = '0;
        out_valid = '0;
        for (int p = 0; p < NPORTS; p++) begin
            grant                 = grant | win[p];
            out_sel[TW*p +: TW]   = onehot_to_idx(win[p]);
            out_valid[p]          = |win[p];
        end
    end

    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            state_nxt[p]  = state[p];
            owner_nxt[p]  = owner[p];
            rr_ptr_nxt[p] = rr_ptr[p];
            if (|win[p]) begin
                if (|(win[p] & req_tail)) begin
                    state_nxt[p]  = IDLE;
                    owner_nxt[p]  = NONE;
                    rr_ptr_nxt[p] = onehot_to_idx(win[p]);
                end else begin
                    state_nxt[p]  = LOCKED;
                    owner_nxt[p]  = onehot_to_idx(win[p]);
                end
            end
        end
    end

    // A return into a full counter is dropped and flagged rather than wrapping.
    always_comb begin
        err_nxt = cred_err;
        for (int k = 0; k < NCRED; k++) begin
            cnt_nxt[k] = cnt[k];
            if (cred_in[k] && !out_valid[k]) begin
                if (cnt[k] == FULL) err_nxt    = 1'b1;
                else                cnt_nxt[k] = cnt[k] + CW'(1);
            end else if (!cred_in[k] && out_valid[k]) begin
                cnt_nxt[k] = cnt[k] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            for (int p = 0; p < NPORTS; p++) begin
                state[p]  <= IDLE;
                owner[p]  <= NONE;
                rr_ptr[p] <= LOCAL;
            end
            for (int k = 0; k < NCRED; k++) begin
                cnt[k] <= FULL;
            end
            cred_err <= 1'b0;
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                state[p]  <= state_nxt[p];
                owner[p]  <= owner_nxt[p];
                rr_ptr[p] <= rr_ptr_nxt[p];
            end
            for (int k = 0; k < NCRED; k++) begin
                cnt[k] <= cnt_nxt[k];
            end
            cred_err <= err_nxt;
        end
    end

    always_comb begin
        for (int k = 0; k < NCRED; k++) begin
            cred_cnt[CW*k +: CW] = cnt[k];
        end
    end

endmodule

// File: tb/tb_credit_sw_arbiter.sv
// Directed bench for credit_sw_arbiter: a per-cycle reference model plus hand-computed checkpoints.
module tb_credit_sw_arbiter;

    localparam int BUF_DEPTH = 4;
    localparam int CW        = 3;

    logic        clk      = 1'b0;
    logic        RST      = 1'b0;
    logic [14:0] req_targ = '0;
    logic [4:0]  req_tail = '0;
    logic [3:0]  cred_in  = '0;
    logic [4:0]  grant;
    logic [14:0] out_sel;
    logic [4:0]  out_valid;
    logic [4*CW-1:0] cred_cnt;
    logic        cred_err;

    int n_checks = 0;
    int n_fail   = 0;

    credit_sw_arbiter #(.BUF_DEPTH(BUF_DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .RST       (RST),
        .req_targ  (req_targ),
        .req_tail  (req_tail),
        .cred_in   (cred_in),
        .grant     (grant),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .cred_cnt  (cred_cnt),
        .cred_err  (cred_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [14:0] tg(input int a, input int b, input int c, input int d, input int e);
        return {3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    // ---------------- reference model (1-based ports and inputs) ----------------
    bit model_valid = 0;
    int m_locked[1:5];
    int m_owner [1:5];
    int m_ptr   [1:5];
    int m_cred  [1:5];
    bit m_err;

    function automatic int targ_of(input int i);
        logic [14:0] t;
        t = req_targ;
        return int'(t[3*(i-1) +: 3]);
    endfunction

    function automatic bit has_credit(input int p);
        return (p == 5) || (m_cred[p] > 0);
    endfunction

    always @(negedge clk) begin
        logic [4:0]      e_grant;
        logic [4:0]      e_valid;
        logic [14:0]     e_sel;
        logic [4*CW-1:0] e_cnt;
        logic [4:0]      tails;
        int              w;
        int              cand;
        int              g;
        e_cnt = '0;
        for (int p = 1; p <= 4; p++) e_cnt[CW*(p-1) +: CW] = CW'(m_cred[p]);
        if (RST === 1'b0) begin
            if (model_valid) begin
                checkOutput("rst_grant", 32'(grant), 32'h0);
                checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
                checkOutput("rst_out_sel", 32'(out_sel), 32'h0);
                checkOutput("rst_cred_cnt", 32'(cred_cnt), 32'(e_cnt));
                checkOutput("rst_cred_err", 32'(cred_err), 32'(m_err));
            end
            for (int p = 1; p <= 5; p++) begin
                m_locked[p] = 0;
                m_owner[p]  = 0;
                m_ptr[p]    = 5;
                m_cred[p]   = BUF_DEPTH;
            end
            m_err       = 0;
            model_valid = 1;
        end else if (model_valid) begin
            checkOutput("model_cred_cnt", 32'(cred_cnt), 32'(e_cnt));
            checkOutput("model_cred_err", 32'(cred_err), 32'(m_err));
            e_grant = '0;
            e_valid = '0;
            e_sel   = '0;
            tails   = req_tail;
            for (int p = 1; p <= 5; p++) begin
                w = 0;
                if (m_locked[p] != 0) begin
                    if (targ_of(m_owner[p]) == p && has_credit(p)) w = m_owner[p];
                end else begin
                    for (int k = 1; k <= 5; k++) begin
                        cand = ((m_ptr[p] + k - 1) % 5) + 1;
                        if (w == 0 && targ_of(cand) == p && has_credit(p)) w = cand;
                    end
                end
                g = 0;
                if (w != 0) begin
                    g = 1;
                    e_grant = e_grant | 5'(1 << (w - 1));
                    e_valid = e_valid | 5'(1 << (p - 1));
                    e_sel[3*(p-1) +: 3] = 3'(w);
                    if (tails[w-1]) begin
                        m_locked[p] = 0;
                        m_owner[p]  = 0;
                        m_ptr[p]    = w;
                    end else begin
                        m_locked[p] = 1;
                        m_owner[p]  = w;
                    end
                end
                if (p <= 4) begin
                    if (cred_in[p-1] && g == 0) begin
                        if (m_cred[p] == BUF_DEPTH) m_err = 1;
                        else                        m_cred[p] = m_cred[p] + 1;
                    end else if (!cred_in[p-1] && g == 1) begin
                        m_cred[p] = m_cred[p] - 1;
                    end
                end
            end
            checkOutput("model_grant", 32'(grant), 32'(e_grant));
            checkOutput("model_out_valid", 32'(out_valid), 32'(e_valid));
            checkOutput("model_out_sel", 32'(out_sel), 32'(e_sel));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic applyStimulus(input logic rst_n, input logic [14:0] t, input logic [4:0] tl, input logic [3:0] c);
        @(posedge clk);
        #1;
        RST      = rst_n;
        req_targ = t;
        req_tail = tl;
        cred_in  = c;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0] exp_a [4];
        logic [4:0] exp_f [5];
        int         cnt_g;
        exp_a = '{5'b00001, 5'b00010, 5'b00100, 5'b00001};
        exp_f = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};

        for (int n = 0; n < 3; n++) applyStimulus(1'b0, '0, '0, '0);
        checkOutput("reset_cred_cnt", 32'(cred_cnt), 32'h924);
        checkOutput("reset_cred_err", 32'(cred_err), 32'h0);
        checkOutput("reset_grant", 32'(grant), 32'h0);

        // Contention: inputs 1-3 single-flit packets to output 2.
        for (int n = 0; n < 4; n++) begin
            applyStimulus(1'b1, tg(2, 2, 2, 0, 0), 5'b00111, 4'b0000);
            checkOutput("contention_grant", 32'(grant), 32'(exp_a[n]));
        end
        for (int n = 0; n < 4; n++) applyStimulus(1'b1, '0, '0, 4'b0010);
        applyStimulus(1'b1, '0, '0, '0);
        checkOutput("contention_restore", 32'(cred_cnt[5:3]), 32'd4);

        // Wormhole lock on output 1; input 3 first moves the pointer so input 4 is next.
        applyStimulus(1'b1, tg(0, 0, 1, 0, 0), 5'b00100, 4'b0001);
        checkOutput("wh_prelude_grant", 32'(grant), 32'b00100);
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b1, tg(0, 1, 0, 1, 0), (n == 2) ? 5'b01010 : 5'b00010, 4'b0001);
            checkOutput("wh_lock_grant", 32'(grant), 32'b01000);
            checkOutput("wh_lock_sel", 32'(out_sel[2:0]), 32'd4);
        end
        applyStimulus(1'b1, tg(0, 1, 0, 0, 0), 5'b00010, 4'b0000);
        checkOutput("wh_after_grant", 32'(grant), 32'b00010);
        checkOutput("wh_after_sel", 32'(out_sel[2:0]), 32'd2);
        applyStimulus(1'b1, '0, '0, 4'b0001);

        // Credit stall on output 3.
        cnt_g = 0;
        for (int n = 0; n < 6; n++) begin
            applyStimulus(1'b1, tg(3, 0, 0, 0, 0), 5'b00001, 4'b0000);
            if (grant[0]) cnt_g++;
        end
        checkOutput("stall_grant_count", 32'(cnt_g), 32'd4);
        checkOutput("stall_cred_zero", 32'(cred_cnt[8:6]), 32'd0);
        checkOutput("stall_grant_off", 32'(grant), 32'd0);
        cnt_g = 0;
        applyStimulus(1'b1, tg(3, 0, 0, 0, 0), 5'b00001, 4'b0100);
        if (grant[0]) cnt_g++;
        for (int n = 0; n < 2; n++) begin
            applyStimulus(1'b1, tg(3, 0, 0, 0, 0), 5'b00001, 4'b0000);
            if (grant[0]) cnt_g++;
        end
        checkOutput("stall_one_more", 32'(cnt_g), 32'd1);
        for (int n = 0; n < 4; n++) applyStimulus(1'b1, '0, '0, 4'b0100);

        // Simultaneous grant and return on output 4, then overflow return.
        for (int n = 0; n < 2; n++) applyStimulus(1'b1, tg(4, 0, 0, 0, 0), 5'b00001, 4'b0000);
        applyStimulus(1'b1, tg(4, 0, 0, 0, 0), 5'b00001, 4'b1000);
        checkOutput("simul_grant", 32'(grant), 32'b00001);
        checkOutput("simul_before", 32'(cred_cnt[11:9]), 32'd2);
        applyStimulus(1'b1, '0, '0, 4'b1000);
        checkOutput("simul_after", 32'(cred_cnt[11:9]), 32'd2);
        applyStimulus(1'b1, '0, '0, 4'b1000);
        applyStimulus(1'b1, '0, '0, 4'b1000);
        checkOutput("overflow_err_before", 32'(cred_err), 32'd0);
        applyStimulus(1'b1, '0, '0, '0);
        checkOutput("overflow_cnt", 32'(cred_cnt[11:9]), 32'd4);
        checkOutput("overflow_err", 32'(cred_err), 32'd1);

        // Reset in the middle of a packet from input 5 on output 4.
        for (int n = 0; n < 2; n++) begin
            applyStimulus(1'b1, tg(0, 0, 0, 0, 4), 5'b00000, 4'b0000);
            checkOutput("midpkt_grant", 32'(grant), 32'b10000);
        end
        applyStimulus(1'b0, tg(0, 0, 0, 0, 4), 5'b00000, 4'b0000);
        checkOutput("midpkt_rst_grant", 32'(grant), 32'd0);
        applyStimulus(1'b1, tg(0, 0, 4, 0, 0), 5'b00100, 4'b0000);
        checkOutput("midpkt_cred", 32'(cred_cnt[11:9]), 32'd4);
        checkOutput("midpkt_err", 32'(cred_err), 32'd0);
        checkOutput("midpkt_new_grant", 32'(grant), 32'b00100);
        checkOutput("midpkt_new_sel", 32'(out_sel[11:9]), 32'd3);
        applyStimulus(1'b1, '0, '0, 4'b1000);

        // Local port: no credit limit; bad targets never granted.
        for (int n = 0; n < 5; n++) begin
            applyStimulus(1'b1, tg(5, 5, 5, 5, 5), 5'b11111, 4'b0000);
            checkOutput("local_grant", 32'(grant), 32'(exp_f[n]));
        end
        for (int n = 0; n < 2; n++) begin
            applyStimulus(1'b1, tg(6, 7, 0, 6, 7), 5'b11111, 4'b0000);
            checkOutput("badtarg_grant", 32'(grant), 32'd0);
            checkOutput("badtarg_valid", 32'(out_valid), 32'd0);
        end
        checkOutput("badtarg_cred", 32'(cred_cnt), 32'h924);

        // A lock whose owner goes quiet stalls other requesters until the tail.
        applyStimulus(1'b1, tg(5, 0, 0, 0, 0), 5'b00000, 4'b0000);
        checkOutput("hold_lock_grant", 32'(grant), 32'b00001);
        for (int n = 0; n < 2; n++) begin
            applyStimulus(1'b1, tg(0, 5, 0, 0, 0), 5'b00010, 4'b0000);
            checkOutput("hold_stall_grant", 32'(grant), 32'd0);
        end
        applyStimulus(1'b1, tg(5, 5, 0, 0, 0), 5'b00011, 4'b0000);
        checkOutput("hold_release_grant", 32'(grant), 32'b00001);
        applyStimulus(1'b1, tg(0, 5, 0, 0, 0), 5'b00010, 4'b0000);
        checkOutput("hold_next_grant", 32'(grant), 32'b00010);
        applyStimulus(1'b1, '0, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
